// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding and
// default parameter values.
package pll_reset_sequencer_pkg;

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_QUALIFY   = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  localparam int DEF_N_STAGES       = 3;
  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT   = 4096;
  localparam int DEF_LOCK_FILTER    = 8;
  localparam int DEF_STAGE_DELAY    = 1024;
  localparam int DEF_MAX_RETRIES    = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Generic two-flop synchronizer for single-bit or bundled level signals
// crossing into i_clk. Each bit is synchronized independently.
module pll_reset_sequencer_sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up and reset-tree sequencer. Holds the PLL in reset, qualifies
// LOCK with a consecutive-high filter, retries on timeout, then releases
// the stage resets one by one. Lock loss restarts the whole sequence.
//
// state       | meaning
// ------------+----------------------------------------------------------
// S_PLL_RST   | o_pll_resetb held low for PLL_RST_CYCLES
// S_WAIT_LOCK | PLL running, waiting for synchronized lock, timeout runs
// S_QUALIFY   | lock seen, counting consecutive high cycles
// S_RELEASE   | stage resets released one per STAGE_DELAY cycles
// S_RUN       | all stages released, o_ready high, watching for lock loss
// S_FAIL      | retries exhausted; only i_rst leaves this state
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int N_STAGES       = DEF_N_STAGES,
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int LOCK_FILTER    = DEF_LOCK_FILTER,
  parameter int STAGE_DELAY    = DEF_STAGE_DELAY,
  parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_pll_lock,
  output logic                             o_pll_resetb,
  output logic [N_STAGES-1:0]              o_rst,
  output logic                             o_ready,
  output logic                             o_fail,
  output logic                             o_lock_lost,
  output logic [$clog2(MAX_RETRIES+1)-1:0] o_retries
);

  localparam int CNT_W = $clog2(max_int(PLL_RST_CYCLES, STAGE_DELAY) + 1);
  localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int FLT_W = $clog2(LOCK_FILTER + 1);
  localparam int RET_W = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST   = CNT_W'(STAGE_DELAY - 1);
  localparam logic [TMO_W-1:0] TMO_LAST     = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [FLT_W-1:0] FLT_LAST     = FLT_W'(LOCK_FILTER - 1);
  localparam logic [RET_W-1:0] RET_MAX      = RET_W'(MAX_RETRIES);

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [TMO_W-1:0]    r_tmo, w_tmo_nxt;
  logic [FLT_W-1:0]    r_flt, w_flt_nxt;
  logic [RET_W-1:0]    r_retries, w_retries_nxt;
  logic                r_pll_resetb, w_pll_resetb_nxt;
  logic [N_STAGES-1:0] r_rst, w_rst_nxt;
  logic                r_ready, w_ready_nxt;
  logic                r_fail, w_fail_nxt;
  logic                r_lock_lost, w_lock_lost_nxt;

  logic                w_lock_s;
  logic                w_timeout;
  logic [N_STAGES-1:0] w_rst_shift;
  logic                w_advance;
  logic                w_go_timeout;
  logic                w_go_loss;

  pll_reset_sequencer_sync_2ff #(.WIDTH(1)) u_lock_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_pll_lock),
    .o_q   (w_lock_s)
  );

  assign w_timeout   = (r_tmo == TMO_LAST);
  // Stages are released LSB first, so shifting zeros in from the bottom
  // walks the release; all-zero means the last stage just went.
  assign w_rst_shift = r_rst << 1;

  // State and registered-output update.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_PLL_RST;
      r_cnt        <= '0;
      r_tmo        <= '0;
      r_flt        <= '0;
      r_retries    <= '0;
      r_pll_resetb <= 1'b0;
      r_rst        <= '1;
      r_ready      <= 1'b0;
      r_fail       <= 1'b0;
      r_lock_lost  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_tmo        <= w_tmo_nxt;
      r_flt        <= w_flt_nxt;
      r_retries    <= w_retries_nxt;
      r_pll_resetb <= w_pll_resetb_nxt;
      r_rst        <= w_rst_nxt;
      r_ready      <= w_ready_nxt;
      r_fail       <= w_fail_nxt;
      r_lock_lost  <= w_lock_lost_nxt;
    end
  end

  // Next-state decode: pick one event per cycle in priority order
  // (lock loss, qualification, timeout, stage advance), then apply it.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_tmo_nxt        = '0;
    w_flt_nxt        = '0;
    w_retries_nxt    = r_retries;
    w_pll_resetb_nxt = r_pll_resetb;
    w_rst_nxt        = r_rst;
    w_ready_nxt      = r_ready;
    w_fail_nxt       = r_fail;
    w_lock_lost_nxt  = r_lock_lost;
    w_advance        = 1'b0;
    w_go_timeout     = 1'b0;
    w_go_loss        = 1'b0;

    unique case (r_state)
      S_PLL_RST: begin
        if (r_cnt == PLL_RST_LAST) begin
          w_state_nxt      = S_WAIT_LOCK;
          w_pll_resetb_nxt = 1'b1;
          w_cnt_nxt        = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        w_tmo_nxt = r_tmo + 1'b1;
        if (w_lock_s && (LOCK_FILTER <= 1)) begin
          w_advance = 1'b1;
        end else if (w_timeout) begin
          w_go_timeout = 1'b1;
        end else if (w_lock_s) begin
          w_state_nxt = S_QUALIFY;
          w_flt_nxt   = FLT_W'(1);
        end
      end
      S_QUALIFY: begin
        // Timeout keeps running across QUALIFY -> WAIT_LOCK bounces.
        w_tmo_nxt = r_tmo + 1'b1;
        if (w_lock_s && (r_flt == FLT_LAST)) begin
          w_advance = 1'b1;
        end else if (w_timeout) begin
          w_go_timeout = 1'b1;
        end else if (w_lock_s) begin
          w_flt_nxt = r_flt + 1'b1;
        end else begin
          w_state_nxt = S_WAIT_LOCK;
        end
      end
      S_RELEASE: begin
        if (!w_lock_s) begin
          w_go_loss = 1'b1;
        end else if (r_cnt == STAGE_LAST) begin
          w_advance = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (!w_lock_s) w_go_loss = 1'b1;
      end
      S_FAIL: begin
      end
      default: begin
        w_state_nxt = S_PLL_RST;
      end
    endcase

    if (w_go_loss) begin
      w_state_nxt      = S_PLL_RST;
      w_cnt_nxt        = '0;
      w_pll_resetb_nxt = 1'b0;
      w_rst_nxt        = '1;
      w_ready_nxt      = 1'b0;
      w_lock_lost_nxt  = 1'b1;
      w_retries_nxt    = '0;
    end

    if (w_advance) begin
      w_rst_nxt = w_rst_shift;
      w_cnt_nxt = '0;
      if (w_rst_shift == '0) begin
        w_state_nxt = S_RUN;
        w_ready_nxt = 1'b1;
      end else begin
        w_state_nxt = S_RELEASE;
      end
    end

    if (w_go_timeout) begin
      w_tmo_nxt        = '0;
      w_cnt_nxt        = '0;
      w_pll_resetb_nxt = 1'b0;
      if (r_retries < RET_MAX) begin
        w_retries_nxt = r_retries + 1'b1;
        w_state_nxt   = S_PLL_RST;
      end else begin
        w_state_nxt = S_FAIL;
        w_fail_nxt  = 1'b1;
      end
    end
  end

  assign o_pll_resetb = r_pll_resetb;
  assign o_rst        = r_rst;
  assign o_ready      = r_ready;
  assign o_fail       = r_fail;
  assign o_lock_lost  = r_lock_lost;
  assign o_retries    = r_retries;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing parameters.
// Inputs change and outputs are sampled on the falling edge.
module tb_pll_reset_sequencer;

  localparam int N_STAGES       = 3;
  localparam int PLL_RST_CYCLES = 4;
  localparam int LOCK_TIMEOUT   = 64;
  localparam int LOCK_FILTER    = 4;
  localparam int STAGE_DELAY    = 8;
  localparam int MAX_RETRIES    = 2;

  // obs layout: {resetb, rst[2:0], ready, fail, lock_lost, retries[1:0]}
  localparam logic [8:0] RST_VAL = 9'b0_111_0_0_0_00;

  logic       i_clk;
  logic       i_rst;
  logic       i_pll_lock;
  logic       o_pll_resetb;
  logic [2:0] o_rst;
  logic       o_ready;
  logic       o_fail;
  logic       o_lock_lost;
  logic [1:0] o_retries;
  logic [8:0] obs;

  int tests = 0;
  int fails = 0;

  assign obs = {o_pll_resetb, o_rst, o_ready, o_fail, o_lock_lost, o_retries};

  pll_reset_sequencer #(
    .N_STAGES       (N_STAGES),
    .PLL_RST_CYCLES (PLL_RST_CYCLES),
    .LOCK_TIMEOUT   (LOCK_TIMEOUT),
    .LOCK_FILTER    (LOCK_FILTER),
    .STAGE_DELAY    (STAGE_DELAY),
    .MAX_RETRIES    (MAX_RETRIES)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_pll_lock   (i_pll_lock),
    .o_pll_resetb (o_pll_resetb),
    .o_rst        (o_rst),
    .o_ready      (o_ready),
    .o_fail       (o_fail),
    .o_lock_lost  (o_lock_lost),
    .o_retries    (o_retries)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] ex(input logic rb, input logic [2:0] r, input logic rdy,
                                    input logic f, input logic ll, input logic [1:0] rt);
    return {rb, r, rdy, f, ll, rt};
  endfunction

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic do_reset(input logic lock_val);
    i_rst      = 1'b1;
    i_pll_lock = lock_val;
    repeat (3) tick();
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    tests++;
    if (obs !== RST_VAL) begin
      fails++;
      $display("FAIL reset_values got=%b exp=%b", obs, RST_VAL);
    end
    for (int n = 1; n <= 4; n++) begin
      tick();
      tests++;
      if (o_pll_resetb !== (n == 4)) begin
        fails++;
        $display("FAIL reset_resetb_width cycle=%0d got=%b exp=%b", n, o_pll_resetb, (n == 4));
      end
    end
  endtask

  task automatic test_nominal();
    logic [2:0] er;
    do_reset(1'b0);
    repeat (4) tick();
    repeat (10) tick();
    i_pll_lock = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      er = (k == 6) ? 3'b110 : 3'b111;
      tests++;
      if (o_rst !== er) begin
        fails++;
        $display("FAIL nominal_rst0 cycle=%0d got=%b exp=%b", k, o_rst, er);
      end
    end
    for (int j = 1; j <= 16; j++) begin
      tick();
      er = (j < 8) ? 3'b110 : (j < 16) ? 3'b100 : 3'b000;
      tests++;
      if (obs !== ex(1'b1, er, (j == 16), 1'b0, 1'b0, 2'd0)) begin
        fails++;
        $display("FAIL nominal_stage cycle=%0d got=%b exp=%b", j, obs,
                 ex(1'b1, er, (j == 16), 1'b0, 1'b0, 2'd0));
      end
    end
    repeat (5) tick();
    tests++;
    if (obs !== ex(1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 2'd0)) begin
      fails++;
      $display("FAIL nominal_run got=%b exp=%b", obs, ex(1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 2'd0));
    end
  endtask

  task automatic test_glitch();
    logic [2:0] er;
    do_reset(1'b0);
    repeat (4) tick();
    i_pll_lock = 1'b1;
    repeat (2) begin
      tick();
      tests++;
      if (o_rst !== 3'b111) begin
        fails++;
        $display("FAIL glitch_high got=%b exp=111", o_rst);
      end
    end
    i_pll_lock = 1'b0;
    repeat (3) begin
      tick();
      tests++;
      if (o_rst !== 3'b111) begin
        fails++;
        $display("FAIL glitch_low got=%b exp=111", o_rst);
      end
    end
    i_pll_lock = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      er = (k == 6) ? 3'b110 : 3'b111;
      tests++;
      if (o_rst !== er) begin
        fails++;
        $display("FAIL glitch_release cycle=%0d got=%b exp=%b", k, o_rst, er);
      end
    end
  endtask

  task automatic test_lock_loss();
    do_reset(1'b0);
    repeat (68) tick();
    tests++;
    if (obs !== ex(1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 2'd1)) begin
      fails++;
      $display("FAIL loss_first_timeout got=%b exp=%b", obs, ex(1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 2'd1));
    end
    i_pll_lock = 1'b1;
    repeat (8) tick();
    tests++;
    if (obs !== ex(1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 2'd1)) begin
      fails++;
      $display("FAIL loss_retry_release got=%b exp=%b", obs, ex(1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 2'd1));
    end
    repeat (16) tick();
    tests++;
    if (obs !== ex(1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 2'd1)) begin
      fails++;
      $display("FAIL loss_run got=%b exp=%b", obs, ex(1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 2'd1));
    end
    i_pll_lock = 1'b0;
    tick();
    i_pll_lock = 1'b1;
    tick();
    tests++;
    if (obs !== ex(1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 2'd1)) begin
      fails++;
      $display("FAIL loss_early got=%b exp=%b", obs, ex(1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 2'd1));
    end
    tick();
    tests++;
    if (obs !== ex(1'b0, 3'b111, 1'b0, 1'b0, 1'b1, 2'd0)) begin
      fails++;
      $display("FAIL loss_response got=%b exp=%b", obs, ex(1'b0, 3'b111, 1'b0, 1'b0, 1'b1, 2'd0));
    end
    for (int n = 4; n <= 7; n++) begin
      tick();
      tests++;
      if (o_pll_resetb !== (n == 7)) begin
        fails++;
        $display("FAIL loss_resetb_width cycle=%0d got=%b exp=%b", n, o_pll_resetb, (n == 7));
      end
    end
    repeat (4) tick();
    tests++;
    if (obs !== ex(1'b1, 3'b110, 1'b0, 1'b0, 1'b1, 2'd0)) begin
      fails++;
      $display("FAIL loss_rerelease got=%b exp=%b", obs, ex(1'b1, 3'b110, 1'b0, 1'b0, 1'b1, 2'd0));
    end
    repeat (16) tick();
    tests++;
    if (obs !== ex(1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 2'd0)) begin
      fails++;
      $display("FAIL loss_rerun got=%b exp=%b", obs, ex(1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 2'd0));
    end
  endtask

  task automatic test_no_lock();
    logic [8:0] e;
    int a;
    int r;
    do_reset(1'b0);
    for (int n = 1; n <= 212; n++) begin
      tick();
      if (n < 204) begin
        a = n / 68;
        r = n % 68;
        e = ex((r >= 4), 3'b111, 1'b0, 1'b0, 1'b0, 2'(a));
      end else begin
        e = ex(1'b0, 3'b111, 1'b0, 1'b1, 1'b0, 2'd2);
      end
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL nolock_seq cycle=%0d got=%b exp=%b", n, obs, e);
      end
    end
  endtask

  task automatic test_reset_in_fail();
    i_rst = 1'b1;
    tick();
    tests++;
    if (obs !== RST_VAL) begin
      fails++;
      $display("FAIL rstfail_values got=%b exp=%b", obs, RST_VAL);
    end
    i_rst = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      tick();
      tests++;
      if (o_pll_resetb !== (n == 4)) begin
        fails++;
        $display("FAIL rstfail_restart cycle=%0d got=%b exp=%b", n, o_pll_resetb, (n == 4));
      end
    end
  endtask

  task automatic test_reset_in_release();
    logic [8:0] e;
    do_reset(1'b1);
    repeat (8) tick();
    tests++;
    if (obs !== ex(1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 2'd0)) begin
      fails++;
      $display("FAIL rstrel_first got=%b exp=%b", obs, ex(1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 2'd0));
    end
    repeat (10) tick();
    tests++;
    if (obs !== ex(1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 2'd0)) begin
      fails++;
      $display("FAIL rstrel_mid got=%b exp=%b", obs, ex(1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 2'd0));
    end
    i_rst = 1'b1;
    tick();
    tests++;
    if (obs !== RST_VAL) begin
      fails++;
      $display("FAIL rstrel_values got=%b exp=%b", obs, RST_VAL);
    end
    i_rst = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      e = ex((n >= 4), (n == 8) ? 3'b110 : 3'b111, 1'b0, 1'b0, 1'b0, 2'd0);
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL rstrel_restart cycle=%0d got=%b exp=%b", n, obs, e);
      end
    end
  endtask

  initial begin
    i_rst      = 1'b1;
    i_pll_lock = 1'b0;
    test_reset();
    test_nominal();
    test_glitch();
    test_lock_loss();
    test_no_lock();
    test_reset_in_fail();
    test_reset_in_release();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Controller for the iCE40 PLL and the design's reset tree. It drives the PLL's active-low reset, qualifies the asynchronous LOCK signal, and retries PLL bring-up on lock timeout. Once lock is stable it releases a chain of downstream resets in a fixed order, and it restarts the whole sequence if lock is lost. It runs on the free-running board reference clock, upstream of every consumer of the PLL output clock.

## Interface
Parameters:
- N_STAGES, 3: number of sequenced reset outputs.
- PLL_RST_CYCLES, 16: cycles o_pll_resetb is held low per attempt.
- LOCK_TIMEOUT, 4096: cycles allowed from o_pll_resetb rising to lock qualified.
- LOCK_FILTER, 8: consecutive synchronized-high cycles required to qualify lock.
- STAGE_DELAY, 1024: cycles between successive stage releases.
- MAX_RETRIES, 3: PLL re-reset attempts before declaring failure.

Ports:
- i_clk, in, 1: reference clock, free-running. One clock for the whole block.
- i_rst, in, 1: synchronous, active-high reset.
- i_pll_lock, in, 1: PLL LOCK, asynchronous to i_clk.
- o_pll_resetb, out, 1: drives PLL RESETB, active low.
- o_rst, out, N_STAGES: active-high stage resets; bit 0 is released first.
- o_ready, out, 1: all stages released, lock good.
- o_fail, out, 1: retries exhausted; sticky.
- o_lock_lost, out, 1: lock dropped after qualification; sticky.
- o_retries, out, $clog2(MAX_RETRIES+1): timeouts in the current bring-up.

## Operation
- i_pll_lock passes through a 2-flop synchronizer to give lock_s. Only lock_s is used internally.
- All outputs are registered. While i_rst is high, and on the edge after it: o_pll_resetb=0, o_rst all 1, o_ready=0, o_fail=0, o_lock_lost=0, o_retries=0, state PLL_RST, counters cleared.
- **PLL_RST:** o_pll_resetb=0 for exactly PLL_RST_CYCLES cycles, then goes to WAIT_LOCK with o_pll_resetb=1. The timeout counter is cleared on entry to WAIT_LOCK.
- **WAIT_LOCK:** the timeout counter runs. When lock_s=1, go to QUALIFY with filter count 1.
- **QUALIFY:** each cycle with lock_s=1 increments the filter count. When the count reaches LOCK_FILTER, go to RELEASE. If lock_s=0, return to WAIT_LOCK; the timeout counter keeps running and is not cleared.
- **Timeout (WAIT_LOCK or QUALIFY):** when the timeout counter reaches LOCK_TIMEOUT without qualification:
  - if o_retries < MAX_RETRIES, increment o_retries and go to PLL_RST;
  - otherwise go to FAIL.
- **RELEASE:** o_rst[0] deasserts on the entry edge. o_rst[k] deasserts exactly k·STAGE_DELAY cycles after o_rst[0]. On the edge that deasserts o_rst[N_STAGES-1], go to RUN and set o_ready=1.
- **Lock loss in RELEASE or RUN:** lock_s=0 for one cycle causes the following on the next edge: all o_rst=1, o_ready=0, o_lock_lost=1, o_retries=0, go to PLL_RST.
- **FAIL:** o_fail=1, o_pll_resetb=0, all o_rst=1. The only exit is i_rst.
- **Priority (highest first):** i_rst, then lock loss, then qualification, then timeout, then stage advance.
  - Qualification and timeout on the same cycle: qualification wins.
  - Lock loss on a stage-release edge: no stage is released.

## Timing
- Synchronizer latency: 2 cycles from i_pll_lock to lock_s.
- If i_pll_lock rises and stays high in WAIT_LOCK, o_rst[0] falls LOCK_FILTER+2 cycles after i_pll_lock rises.
- o_ready rises (N_STAGES-1)·STAGE_DELAY cycles after o_rst[0] falls.
- Lock loss: o_rst returns to all 1s 3 cycles after i_pll_lock falls.
- A full timeout attempt lasts PLL_RST_CYCLES + LOCK_TIMEOUT cycles.
- o_fail rises after (MAX_RETRIES+1) attempts.
- Counter widths:
  - the shared stage/PLL-reset counter is sized to max(PLL_RST_CYCLES, STAGE_DELAY);
  - the timeout counter is sized to LOCK_TIMEOUT;
  - no counter wraps; each is cleared on every state change that uses it.

## Structure
- Shared package holds the state encoding (PLL_RST, WAIT_LOCK, QUALIFY, RELEASE, RUN, FAIL) and the default parameter constants.
- One sub-module: sync_2ff, a generic 2-flop synchronizer that is also reused by other clock-crossing inputs. The filter stays in the FSM.

## Test plan
Bench parameters: N_STAGES=3, PLL_RST_CYCLES=4, LOCK_TIMEOUT=64, LOCK_FILTER=4, STAGE_DELAY=8, MAX_RETRIES=2.

1. **Nominal bring-up.** Raise i_pll_lock 10 cycles after o_pll_resetb rises and hold it high.
   - o_rst[0] falls 6 cycles later.
   - o_rst[1] falls 8 cycles after that; o_rst[2] falls 16 cycles after o_rst[0], with o_ready=1 on the same edge.
2. **No lock.** Hold i_pll_lock=0.
   - Three o_pll_resetb low pulses of 4 cycles each, 64 cycles apart.
   - o_retries steps 0→1→2.
   - o_fail=1 after the third timeout; o_rst stays 111.
3. **Lock glitch.** i_pll_lock high for 2 cycles, low for 3, then stable high.
   - No release during the glitch.
   - o_rst[0] falls 6 cycles after the final rise.
4. **Lock loss in RUN.** Drop i_pll_lock for 1 cycle.
   - 3 cycles later: o_rst=111, o_ready=0, o_lock_lost=1, o_retries=0.
   - o_pll_resetb is low for 4 cycles, then the full sequence repeats.
5. **Reset mid-operation.** Assert i_rst in the middle of RELEASE (o_rst=100), and separately in FAIL.
   - Next edge: all outputs at reset values.
   - A new bring-up starts after i_rst deasserts.
